// File: rtl/store_buffer.sv
// Posted-write store buffer between the MEM stage and a single-port data memory.
// Optional macro SB_FORWARD_EN: youngest-match load forwarding instead of load stalls.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          MemWriteM,
    input  logic          MemToRegM,
    input  logic [31:0]   ALUOutM,
    input  logic [31:0]   WriteDataM,
    output logic [31:0]   ReadDataM,
    output logic          StallSB,
    output logic [31:0]   MemA,
    output logic [31:0]   MemWD,
    output logic          MemWE,
    input  logic [31:0]   MemRD,
    output logic [CW-1:0] Count,
    output logic          Empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]    addr_q [DEPTH];
    logic [31:0]    data_q [DEPTH];
    logic [AW-1:0]  head_q, head_d;
    logic [AW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;

    logic             full, empty;
    logic             load_req, hazard, load_owns;
    logic             push, pop, any_match;
    logic [DEPTH-1:0] match_vec;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    // A simultaneous store and load is treated as a store only.
    assign load_req = MemToRegM & ~MemWriteM;

    // Entry gi is valid when its distance from head is below the count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        logic [AW-1:0] off;
        assign off           = AW'(gi) - head_q;
        assign match_vec[gi] = (CW'(off) < count_q) && (addr_q[gi] == ALUOutM);
    end

    assign any_match = |match_vec;

`ifdef SB_FORWARD_EN
    logic [31:0] fwd_data;

    // Walk oldest to youngest so the last hit (closest to tail) wins.
    always_comb begin
        logic [AW-1:0] idx;
        fwd_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + AW'(k);
            if (match_vec[idx]) begin
                fwd_data = data_q[idx];
            end
        end
    end

    assign hazard    = 1'b0;
    assign ReadDataM = (load_req && any_match) ? fwd_data : MemRD;
`else
    assign hazard    = load_req & any_match;
    assign ReadDataM = MemRD;
`endif

    assign load_owns = load_req & ~hazard;
    assign push      = RST_N & MemWriteM & ~full;
    assign pop       = RST_N & ~load_owns & ~empty;

    assign MemWE   = pop;
    assign MemA    = pop ? addr_q[head_q] : ALUOutM;
    assign MemWD   = data_q[head_q];
    assign StallSB = RST_N & ((MemWriteM & full) | hazard);
    assign Count   = count_q;
    assign Empty   = empty;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            head_d = head_q + AW'(1);
        end
        if (push) begin
            tail_d = tail_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset so it can map onto RAM.
    always_ff @(posedge CLK) begin
        if (push) begin
            addr_q[tail_q] <= ALUOutM;
            data_q[tail_q] <= WriteDataM;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Randomized scoreboard bench for store_buffer against a queue-based reference model.
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          MemWriteM = 1'b0;
    logic          MemToRegM = 1'b0;
    logic [31:0]   ALUOutM = '0;
    logic [31:0]   WriteDataM = '0;
    logic [31:0]   ReadDataM;
    logic          StallSB;
    logic [31:0]   MemA;
    logic [31:0]   MemWD;
    logic          MemWE;
    logic [31:0]   MemRD;
    logic [CW-1:0] Count;
    logic          Empty;

    int total = 0;
    int bad   = 0;

    store_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .CLK(CLK), .RST_N(RST_N), .MemWriteM(MemWriteM), .MemToRegM(MemToRegM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM),
        .StallSB(StallSB), .MemA(MemA), .MemWD(MemWD), .MemWE(MemWE),
        .MemRD(MemRD), .Count(Count), .Empty(Empty)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] init_val(input logic [5:0] i);
        return 32'hC0DE_0000 + 32'(i) * 32'h111;
    endfunction

    // Physical data memory seen by the DUT (64 words, indexed by low address bits).
    bit [31:0] phys_mem [64];
    bit        written  [64];
    always @(posedge CLK) begin
        if (MemWE) begin
            phys_mem[MemA[5:0]] <= MemWD;
            written[MemA[5:0]]  <= 1'b1;
        end
    end
    assign MemRD = written[MemA[5:0]] ? phys_mem[MemA[5:0]] : init_val(MemA[5:0]);

    // Reference model: pending stores in program order plus the memory image.
    logic [31:0] pq_a [$];
    logic [31:0] pq_d [$];
    logic [31:0] model_mem [64];

    // Scoreboard queues filled by stimulus, drained by the monitor.
    logic [31:0] exp_wa [$];
    logic [31:0] exp_wd [$];
    logic [31:0] exp_ld [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic r, input logic w, input logic l,
                         input logic [31:0] a, input logic [31:0] d);
        logic        ld_eff, match, hz, exp_stall, was_full, drain;
        logic [31:0] yd;
        @(negedge CLK);
        check("count", 32'(Count), 32'(pq_a.size()));
        check("empty", 32'(Empty), 32'(pq_a.size() == 0));
        RST_N = r; MemWriteM = w; MemToRegM = l; ALUOutM = a; WriteDataM = d;
        #1;
        ld_eff = l & ~w;
        match  = 1'b0;
        yd     = '0;
        foreach (pq_a[i]) begin
            if (pq_a[i] == a) begin
                match = 1'b1;
                yd    = pq_d[i];
            end
        end
        if (!r) begin
            check("stall_rst", 32'(StallSB), 32'd0);
            pq_a.delete();
            pq_d.delete();
            return;
        end
`ifdef SB_FORWARD_EN
        hz = 1'b0;
`else
        hz = ld_eff & match;
`endif
        was_full  = (pq_a.size() == DEPTH);
        exp_stall = (w && was_full) || hz;
        check("stall", 32'(StallSB), 32'(exp_stall));
        if (ld_eff && !exp_stall) begin
            exp_ld.push_back(match ? yd : model_mem[a[5:0]]);
        end
        drain = !(ld_eff && !hz) && (pq_a.size() > 0);
        if (drain) begin
            exp_wa.push_back(pq_a[0]);
            exp_wd.push_back(pq_d[0]);
            model_mem[pq_a[0][5:0]] = pq_d[0];
            void'(pq_a.pop_front());
            void'(pq_d.pop_front());
        end
        if (w && !was_full) begin
            pq_a.push_back(a);
            pq_d.push_back(d);
        end
        $display("cyc rst_n=%0b we=%0b ld=%0b a=%h d=%h stall=%0b memwe=%0b pend=%0d",
                 r, w, l, a, d, StallSB, MemWE, pq_a.size());
    endtask

    // Monitor: compares every memory write and every accepted load result.
    initial begin
        forever begin
            @(negedge CLK);
            #2;
            if (MemWE) begin
                check("wr_expected", 32'(exp_wa.size() > 0), 32'd1);
                if (exp_wa.size() > 0) begin
                    check("wr_addr", MemA, exp_wa.pop_front());
                    check("wr_data", MemWD, exp_wd.pop_front());
                end
            end
            if (RST_N && MemToRegM && !MemWriteM && !StallSB) begin
                check("ld_expected", 32'(exp_ld.size() > 0), 32'd1);
                if (exp_ld.size() > 0) begin
                    check("ld_data", ReadDataM, exp_ld.pop_front());
                end
            end
        end
    end

    function automatic logic [31:0] rand_addr();
        int s;
        s = $urandom_range(0, 9);
        if (s < 8) return 32'(s);
        if (s == 8) return 32'h40;
        return 32'h200;
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) model_mem[i] = init_val(6'(i));

        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        // Single store then idle drain.
        cycle(1, 1, 0, 32'h10, 32'hDEADBEEF);
        cycle(1, 0, 0, 32'h0, 32'h0);
        cycle(1, 0, 0, 32'h0, 32'h0);
        cycle(1, 0, 1, 32'h10, 32'h0);
        // Two stores to one address, then loads of it.
        cycle(1, 1, 0, 32'h40, 32'h11);
        cycle(1, 0, 1, 32'h200, 32'h0);
        cycle(1, 1, 0, 32'h40, 32'h22);
        cycle(1, 0, 1, 32'h40, 32'h0);
        cycle(1, 0, 1, 32'h40, 32'h0);
        cycle(1, 0, 1, 32'h40, 32'h0);
        // Non-matching load, then drain resumes.
        cycle(1, 1, 0, 32'h40, 32'h33);
        cycle(1, 0, 1, 32'h44, 32'h0);
        cycle(1, 0, 0, 32'h0, 32'h0);
        // Illegal store+load is a store only.
        cycle(1, 1, 1, 32'h5, 32'h55);
        cycle(1, 0, 1, 32'h5, 32'h0);
        // Pointer wrap: ten stores interleaved with drains and loads.
        for (int i = 0; i < 10; i++) begin
            cycle(1, 1, 0, 32'(i), 32'hA000 + 32'(i));
            cycle(1, 0, (i % 2) == 0, 32'h200, 32'h0);
        end
        // Reset with a store pending discards it.
        cycle(1, 1, 0, 32'h7, 32'h77);
        cycle(0, 0, 0, 32'h0, 32'h0);
        cycle(1, 0, 1, 32'h7, 32'h0);
        cycle(1, 0, 0, 32'h0, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            logic r, w, l;
            r = ($urandom_range(0, 99) != 0);
            w = ($urandom_range(0, 99) < 45);
            l = ($urandom_range(0, 99) < 45);
            cycle(r, w, l, rand_addr(), $urandom);
        end
        for (int n = 0; n < 4; n++) cycle(1, 0, 0, 32'h0, 32'h0);

        @(negedge CLK);
        #3;
        check("wr_left", 32'(exp_wa.size()), 32'd0);
        check("ld_left", 32'(exp_ld.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
